count_stream_checker: RTL and testbench
=======================================

Name: count_stream_checker

Overview:
- Receive-side companion to the 8-bit pin counter: samples a count value arriving on dedicated inputs, for example from a second tile or chip running the counter.
- Checks that each sample is exactly one step from the previous sample, in the direction given by the direction input.
- Reports lock status, a one-cycle mismatch pulse and a saturating error tally.
- Sits inside a top-level pin wrapper, between ui_in and the status outputs.

Parameters:
- bits, 8, width of the monitored count value.
- lock_count, 4, consecutive correct steps required to declare lock; legal range 1..15.
- err_w, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- count_in  input  bits  count value under test.
- sample_en  input  1  count_in is valid this cycle; nothing updates when low.
- dir  input  1  expected direction: 0 = up (+1), 1 = down (-1); evaluated per sample.
- clr  input  1  synchronous clear of err_count only.
- locked  output  1  high while the state is LOCKED (registered).
- mismatch  output  1  one-cycle pulse on a bad step while LOCKED (registered).
- err_count  output  err_w  saturating count of mismatches seen while LOCKED.
- last_sample  output  bits  most recently accepted count_in.

Behaviour:
- Reset (async, rst=1): state=IDLE, good_cnt=0, locked=0, mismatch=0, err_count=0, last_sample=0. Reset mid-operation discards lock and history immediately.
- Reference value: exp = last_sample+1 mod 2^bits when dir=0, last_sample-1 mod 2^bits when dir=1.
  - Wrap is legal: up 255->0 and down 0->255 (bits=8) count as matches.
- All outputs are registered; an effect appears the cycle after the sampling edge (latency 1).
- When sample_en=0, all state holds and mismatch=0.
- On every sample (sample_en=1): last_sample <= count_in, regardless of state or match.
- IDLE, on sample: go to ACQUIRE, good_cnt=0. No comparison is made because there is no history.
- ACQUIRE, on sample:
  - Match: good_cnt++. If the new good_cnt equals lock_count, go to LOCKED and clear good_cnt.
  - Mismatch: good_cnt=0, stay in ACQUIRE. No mismatch pulse, no err_count change.
- LOCKED, on sample:
  - Match: stay in LOCKED.
  - Mismatch: mismatch=1 for exactly one cycle, err_count increments (saturating), go to ACQUIRE with good_cnt=0, locked falls on the same edge.
- Direction: dir is compared per sample. A dir change between samples is simply part of the expectation; a stream that reverses while dir stays constant is a mismatch.
- Repeated value (count_in == last_sample) is a mismatch.
- err_count saturates at 2^err_w-1 and never wraps.
- clr=1: err_count <= 0. If clr coincides with a counted mismatch, clr wins (err_count=0), but the mismatch pulse and the state transition still occur.
- lock_count=1: a single correct step after the first sample locks.

Test Plan:
- Reset, then samples 10,11,12,13,14 with dir=0, lock_count=4 -> locked=1 the cycle after sample 14; err_count=0; last_sample=14.
- While locked up, samples 254,255,0,1 (each consecutive) -> locked stays 1, mismatch never asserts; then dir=1 with samples 255,254,... continuing downward from 0 -> locked held throughout.
- While locked, count_in=50 when exp=21 -> mismatch=1 for one cycle, err_count=1, locked=0; then 51,52,53,54 -> relocked.
- Drive 300 locked/mismatch cycles with err_w=8 -> err_count stops at 255. Assert clr on the same cycle as a mismatch -> err_count=0, mismatch pulse still seen.
- sample_en=0 for 20 cycles mid-lock with count_in toggling randomly -> no state, output or last_sample change; resume with exp -> still locked.
- Assert rst asynchronously (between clock edges) while locked, err_count=3 -> all outputs 0 immediately. First sample after release -> ACQUIRE, not locked.

Source files
------------

// File: rtl/count_stream_checker_if.sv
// Bundles the count stream under test with the checker's status outputs.
// The producer side (pin wrapper or bench) uses master; the checker uses slave.
interface count_stream_checker_if #(
    parameter int bits  = 8,
    parameter int err_w = 8
);
    logic [bits-1:0]  count_in;
    logic             sample_en;
    logic             dir;
    logic             clr;
    logic             locked;
    logic             mismatch;
    logic [err_w-1:0] err_count;
    logic [bits-1:0]  last_sample;

    modport master (
        output count_in, sample_en, dir, clr,
        input  locked, mismatch, err_count, last_sample
    );

    modport slave (
        input  count_in, sample_en, dir, clr,
        output locked, mismatch, err_count, last_sample
    );
endinterface

// File: rtl/count_stream_checker.sv
// Checks that a sampled count stream steps by exactly one in the direction
// given by dir; reports lock, a one-cycle mismatch pulse and an error tally.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | no history yet; first sample only seeds last_sample
//  S_ACQ   | counting consecutive good steps towards lock_count
//  S_LOCK  | locked; a bad step pulses mismatch and drops back to S_ACQ
module count_stream_checker #(
    parameter int bits       = 8,
    parameter int lock_count = 4,
    parameter int err_w      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    count_stream_checker_if.slave bus
);
    localparam logic [1:0]       S_IDLE  = 2'd0;
    localparam logic [1:0]       S_ACQ   = 2'd1;
    localparam logic [1:0]       S_LOCK  = 2'd2;
    localparam logic [3:0]       LOCK_N  = 4'(lock_count);
    localparam logic [err_w-1:0] ERR_MAX = '1;
    localparam logic [bits-1:0]  ONE     = bits'(1);

    logic [1:0]       state;
    logic [3:0]       good_cnt;
    logic [3:0]       good_nxt;
    logic             mismatch_q;
    logic [err_w-1:0] err_q;
    logic [bits-1:0]  last_q;
    logic [bits-1:0]  exp_val;
    logic             hit;

    // Modular arithmetic makes the 0 <-> max wrap a legal step in both directions.
    assign exp_val  = bus.dir ? (last_q - ONE) : (last_q + ONE);
    assign hit      = (bus.count_in == exp_val);
    assign good_nxt = good_cnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            good_cnt   <= 4'd0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
            last_q     <= '0;
        end else begin
            mismatch_q <= 1'b0;
            if (bus.clr)
                err_q <= '0;
            if (bus.sample_en) begin
                last_q <= bus.count_in;
                case (state)
                    S_IDLE: begin
                        state    <= S_ACQ;
                        good_cnt <= 4'd0;
                    end
                    S_ACQ: begin
                        if (!hit) begin
                            good_cnt <= 4'd0;
                        end else if (good_nxt == LOCK_N) begin
                            state    <= S_LOCK;
                            good_cnt <= 4'd0;
                        end else begin
                            good_cnt <= good_nxt;
                        end
                    end
                    S_LOCK: begin
                        if (!hit) begin
                            mismatch_q <= 1'b1;
                            state      <= S_ACQ;
                            good_cnt   <= 4'd0;
                            // A coincident clr takes priority over the count.
                            if (!bus.clr && err_q != ERR_MAX)
                                err_q <= err_q + 1'b1;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        good_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign bus.locked      = (state == S_LOCK);
    assign bus.mismatch    = mismatch_q;
    assign bus.err_count   = err_q;
    assign bus.last_sample = last_q;
endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker: a vector table for the main stream
// plus hand sequences for saturation, sample gating, async reset and lock_count=1.
module tb_count_stream_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    count_stream_checker_if #(.bits(8), .err_w(8)) bus ();
    count_stream_checker_if #(.bits(8), .err_w(8)) bus1 ();

    count_stream_checker #(.bits(8), .lock_count(4), .err_w(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    count_stream_checker #(.bits(8), .lock_count(1), .err_w(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        logic       en;
        logic       d;
        logic       c;
        logic [7:0] v;
        logic       lk;
        logic       mm;
        logic [7:0] err;
        logic [7:0] last;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] cur;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic addv(input logic en, input logic d, input logic c, input logic [7:0] v,
                        input logic lk, input logic mm, input logic [7:0] err, input logic [7:0] last);
        vec_t t;
        t.en = en; t.d = d; t.c = c; t.v = v;
        t.lk = lk; t.mm = mm; t.err = err; t.last = last;
        tbl.push_back(t);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic drive(input logic en, input logic d, input logic c, input logic [7:0] v);
        bus.sample_en = en;
        bus.dir       = d;
        bus.clr       = c;
        bus.count_in  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic en, input logic [7:0] v);
        bus1.sample_en = en;
        bus1.dir       = 1'b0;
        bus1.clr       = 1'b0;
        bus1.count_in  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic bad_step(input logic c);
        cur = cur + 8'd3;
        drive(1'b1, 1'b0, c, cur);
    endtask

    task automatic relock();
        for (int k = 0; k < 4; k++) begin
            cur = cur + 8'd1;
            drive(1'b1, 1'b0, 1'b0, cur);
        end
    endtask

    initial begin
        bus.sample_en = 1'b0; bus.dir = 1'b0; bus.clr = 1'b0; bus.count_in = 8'd0;
        bus1.sample_en = 1'b0; bus1.dir = 1'b0; bus1.clr = 1'b0; bus1.count_in = 8'd0;

        // Up-count acquisition and lock, then a bad step and relock.
        addv(1,0,0, 10, 0,0,0, 10);
        addv(1,0,0, 11, 0,0,0, 11);
        addv(1,0,0, 12, 0,0,0, 12);
        addv(1,0,0, 13, 0,0,0, 13);
        addv(1,0,0, 14, 1,0,0, 14);
        for (int i = 15; i <= 20; i++) addv(1,0,0, 8'(i), 1,0,0, 8'(i));
        addv(1,0,0, 50, 0,1,1, 50);
        addv(1,0,0, 51, 0,0,1, 51);
        addv(1,0,0, 52, 0,0,1, 52);
        addv(1,0,0, 53, 0,0,1, 53);
        addv(1,0,0, 54, 1,0,1, 54);
        // Relock near the top, wrap up through 0, then reverse direction and wrap down.
        addv(1,0,0, 250, 0,1,2, 250);
        addv(1,0,0, 251, 0,0,2, 251);
        addv(1,0,0, 252, 0,0,2, 252);
        addv(1,0,0, 253, 0,0,2, 253);
        addv(1,0,0, 254, 1,0,2, 254);
        addv(1,0,0, 255, 1,0,2, 255);
        addv(1,0,0,   0, 1,0,2,   0);
        addv(1,0,0,   1, 1,0,2,   1);
        addv(1,1,0,   0, 1,0,2,   0);
        addv(1,1,0, 255, 1,0,2, 255);
        addv(1,1,0, 254, 1,0,2, 254);
        addv(0,1,0,  77, 1,0,2, 254);
        // Repeated value, then a reversal while dir stays up (mismatch inside acquire).
        addv(1,1,0, 254, 0,1,3, 254);
        addv(1,0,0, 255, 0,0,3, 255);
        addv(1,0,0, 254, 0,0,3, 254);
        addv(1,1,0, 253, 0,0,3, 253);
        addv(1,1,0, 252, 0,0,3, 252);
        addv(1,1,0, 251, 0,0,3, 251);
        addv(1,1,0, 250, 1,0,3, 250);
        addv(0,1,1,  99, 1,0,0, 250);

        #2;
        chk("rst_locked",   bus.locked,      0);
        chk("rst_mismatch", bus.mismatch,    0);
        chk("rst_err",      bus.err_count,   0);
        chk("rst_last",     bus.last_sample, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // lock_count=1: one good step after the first sample locks.
        drive1(1'b1, 8'd7);
        chk("lc1_first_locked", bus1.locked, 0);
        drive1(1'b1, 8'd8);
        chk("lc1_locked", bus1.locked, 1);
        drive1(1'b1, 8'd20);
        chk("lc1_mismatch", bus1.mismatch, 1);
        chk("lc1_err", bus1.err_count, 1);
        chk("lc1_unlocked", bus1.locked, 0);
        drive1(1'b0, 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].d, tbl[i].c, tbl[i].v);
            chk($sformatf("vec%0d_locked", i),   bus.locked,      tbl[i].lk);
            chk($sformatf("vec%0d_mismatch", i), bus.mismatch,    tbl[i].mm);
            chk($sformatf("vec%0d_err", i),      bus.err_count,   tbl[i].err);
            chk($sformatf("vec%0d_last", i),     bus.last_sample, tbl[i].last);
        end

        // Saturation: 300 locked mismatches, each followed by a relock.
        cur = 8'd250;
        for (int i = 0; i < 300; i++) begin
            bad_step(1'b0);
            chk("sat_mismatch", bus.mismatch, 1);
            chk("sat_err", bus.err_count, (i + 1 > 255) ? 255 : i + 1);
            relock();
        end
        chk("sat_final_err", bus.err_count, 255);
        chk("sat_relocked", bus.locked, 1);

        bad_step(1'b1);
        chk("clr_mm_pulse", bus.mismatch, 1);
        chk("clr_mm_err", bus.err_count, 0);
        chk("clr_mm_locked", bus.locked, 0);
        relock();
        chk("clr_relock", bus.locked, 1);

        // Gated samples: random junk on the inputs must not move anything.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom_range(0, 255)));
            chk("hold_locked",   bus.locked,      1);
            chk("hold_mismatch", bus.mismatch,    0);
            chk("hold_err",      bus.err_count,   0);
            chk("hold_last",     bus.last_sample, int'(cur));
        end
        cur = cur + 8'd1;
        drive(1'b1, 1'b0, 1'b0, cur);
        chk("resume_locked", bus.locked, 1);
        chk("resume_last", bus.last_sample, int'(cur));

        for (int i = 0; i < 3; i++) begin
            bad_step(1'b0);
            relock();
        end
        chk("pre_rst_err", bus.err_count, 3);
        chk("pre_rst_locked", bus.locked, 1);

        // Asynchronous reset between edges clears everything immediately.
        #3;
        rst = 1'b1;
        #1;
        chk("arst_locked",   bus.locked,      0);
        chk("arst_mismatch", bus.mismatch,    0);
        chk("arst_err",      bus.err_count,   0);
        chk("arst_last",     bus.last_sample, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cur = cur + 8'd1;
        drive(1'b1, 1'b0, 1'b0, cur);
        chk("post_rst_locked", bus.locked, 0);
        chk("post_rst_last", bus.last_sample, int'(cur));
        cur = cur + 8'd1;
        drive(1'b1, 1'b0, 1'b0, cur);
        chk("post_rst_acq", bus.locked, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
